// File: rtl/ntt_pkg.sv
// Shared types and size helpers for the NTT sequencing logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ntt_pkg;

  localparam int LOGN_DEF      = 8;
  localparam int RADIX_LOG_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_GAP   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Number of radix passes over the data (K).
  function automatic int num_stages(input int logn, input int radix_log);
    return logn / radix_log;
  endfunction

  // Number of radix-sized groups visited per pass (G).
  function automatic int num_groups(input int logn, input int radix_log);
    return 1 << (logn - radix_log);
  endfunction

  // Bits needed to index n items, never less than one.
  function automatic int width_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int stage_w(input int logn, input int radix_log);
    return width_of(num_stages(logn, radix_log));
  endfunction

  function automatic int grp_w(input int logn, input int radix_log);
    return ((logn - radix_log) < 1) ? 1 : (logn - radix_log);
  endfunction

  // Gap counter must hold PIPE_LAT+1 after its final increment.
  function automatic int gap_w(input int pipe_lat);
    return $clog2(pipe_lat + 2);
  endfunction

endpackage

// File: rtl/en_delay.sv
// Fixed-depth shift register that aligns enable/flag bits with BFU write-back.
// Latency: DEPTH cycles from din to dout.
// Backpressure: none; advances every cycle, cleared by reset so in-flight bits are dropped.
module en_delay #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] pipe [DEPTH];

      // Shift din through DEPTH registers; reset discards everything in flight
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= din;
          for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign dout = pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/ntt_seq_ctrl.sv
// Sequences the AGU over K stages of G groups with a hazard gap between stages.
// Latency: agu_en one cycle after start; wb_en/wb_last trail agu_en by PIPE_LAT cycles.
// Backpressure: none; start is accepted only in IDLE and ignored otherwise.
module ntt_seq_ctrl
  import ntt_pkg::*;
#(
  parameter int LOGN      = LOGN_DEF,
  parameter int RADIX_LOG = RADIX_LOG_DEF,
  parameter int PIPE_LAT  = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  output logic                                 agu_en,
  output logic [stage_w(LOGN, RADIX_LOG)-1:0]  stage,
  output logic [grp_w(LOGN, RADIX_LOG)-1:0]    grp,
  output logic                                 wb_en,
  output logic                                 wb_last,
  output logic                                 busy,
  output logic                                 done
);

  localparam int K  = num_stages(LOGN, RADIX_LOG);
  localparam int G  = num_groups(LOGN, RADIX_LOG);
  localparam int SW = stage_w(LOGN, RADIX_LOG);
  localparam int GW = grp_w(LOGN, RADIX_LOG);
  localparam int CW = gap_w(PIPE_LAT);

  localparam logic [SW-1:0] STAGE_LAST = SW'(K - 1);
  localparam logic [GW-1:0] GRP_LAST   = GW'(G - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(PIPE_LAT);

  generate
    if ((RADIX_LOG < 1) || (LOGN < RADIX_LOG) || ((LOGN % RADIX_LOG) != 0)) begin : g_bad_param
      $error("ntt_seq_ctrl: LOGN must be a non-zero multiple of RADIX_LOG");
    end
  endgenerate

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   gap_cnt;
  logic            grp_end;
  logic            stage_end;
  logic            gap_end;
  logic            agu_en_nxt;
  logic            busy_nxt;
  logic            done_nxt;
  logic            last_tap;
  logic [1:0]      dly_in;
  logic [1:0]      dly_out;

  assign grp_end   = (grp == GRP_LAST);
  assign stage_end = (stage == STAGE_LAST);
  assign gap_end   = (gap_cnt == GAP_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: a stage is one unbroken burst of G enables, then a gap or the final drain
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start)   state_nxt = ST_RUN;
      ST_RUN:   if (grp_end) state_nxt = stage_end ? ST_DRAIN : ST_GAP;
      ST_GAP:   if (gap_end) state_nxt = ST_RUN;
      ST_DRAIN: if (gap_end) state_nxt = ST_DONE;
      ST_DONE:               state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every control output comes straight off a flop
  always_comb begin
    agu_en_nxt = 1'b0;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    agu_en_nxt = (state_nxt == ST_RUN);
    busy_nxt   = (state_nxt != ST_IDLE);
    done_nxt   = (state_nxt == ST_DONE);
  end

  // Registered control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      agu_en <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      agu_en <= agu_en_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

  // Group/stage/gap counters; gap counter restarts from 0 on every GAP or DRAIN entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grp     <= '0;
      stage   <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          grp <= grp_end ? '0 : grp + 1'b1;
          if (grp_end) gap_cnt <= '0;
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_end) stage <= stage + 1'b1;
        end
        ST_DRAIN: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_end) stage <= '0;
        end
        default: begin
          grp     <= '0;
          gap_cnt <= '0;
        end
      endcase
    end
  end

  // The final group of the final stage tags the write-back that closes the transform
  assign last_tap = agu_en & stage_end & grp_end;
  assign dly_in   = {last_tap, agu_en};

  en_delay #(
    .DEPTH (PIPE_LAT),
    .WIDTH (2)
  ) u_wb_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (dly_in),
    .dout (dly_out)
  );

  assign wb_en   = dly_out[0];
  assign wb_last = dly_out[1];

endmodule
